// File: rtl/circle_pixel_writer.sv
// Clips rasterised circle points to the screen, converts them to linear framebuffer
// addresses, buffers them in a small FWFT FIFO and drains them over a we/ack handshake.
module circle_pixel_writer #(
  parameter int unsigned H_RES      = 160,
  parameter int unsigned V_RES      = 120,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned COLOR_W    = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [8:0]         pt_x,
  input  logic [7:0]         pt_y,
  input  logic [COLOR_W-1:0] color,
  input  logic               src_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ack,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        pix_count,
  output logic [15:0]        clip_count
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = ADDR_W + COLOR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        pix_q, pix_d;
  logic [15:0]        clip_q, clip_d;

  logic               fifo_full, fifo_empty;
  logic               accept, in_view, push, pop, clip;
  int                 pt_xs, pt_ys;
  logic [ADDR_W-1:0]  pt_addr;

  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Signed clip test on the raw upstream coordinates
  assign pt_xs   = int'($signed(pt_x));
  assign pt_ys   = int'($signed(pt_y));
  assign in_view = (pt_xs >= 0) && (pt_xs < int'(H_RES)) &&
                   (pt_ys >= 0) && (pt_ys < int'(V_RES));
  assign pt_addr = (ADDR_W'(pt_y) * ADDR_W'(H_RES)) + ADDR_W'(pt_x);

  assign pt_ready = (state_q == S_RUN) && !fifo_full;
  assign accept   = pt_valid && pt_ready;
  assign push     = accept && in_view;
  assign clip     = accept && !in_view;
  assign pop      = fb_we && fb_ack;

  assign fb_we                = !fifo_empty;
  assign {fb_addr, fb_data}   = fifo_empty ? ENTRY_W'(0) : mem_q[rd_ptr_q];
  assign busy                 = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign frame_done           = (state_q == S_DONE);
  assign pix_count            = pix_q;
  assign clip_count           = clip_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pix_d    = pix_q;
    clip_d   = clip_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pix_d   = '0;
          clip_d  = '0;
        end
      end
      S_RUN:   if (src_done) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Counters stick at all-ones rather than wrapping
    if (pop && (pix_q != 16'hFFFF))   pix_d  = pix_q + 16'd1;
    if (clip && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pix_q    <= '0;
      clip_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pix_q    <= pix_d;
      clip_q   <= clip_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pt_addr, color};
  end

endmodule

// File: tb/tb_circle_pixel_writer.sv
// Self-checking bench for circle_pixel_writer: a transaction-level model predicts
// the ordered framebuffer writes and the pixel/clip counts.
module tb_circle_pixel_writer;

  localparam int H = 160;
  localparam int V = 120;

  logic        clk = 1'b0;
  logic        reset, start, pt_valid, pt_ready, src_done;
  logic [8:0]  pt_x;
  logic [7:0]  pt_y;
  logic [11:0] color, fb_data;
  logic [14:0] fb_addr;
  logic        fb_we, fb_ack, busy, frame_done;
  logic [15:0] pix_count, clip_count;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [26:0] exp_q[$];
  logic [26:0] obs_q[$];
  int          exp_kept, exp_clip;
  bit          ack_rand = 1'b0;

  circle_pixel_writer dut (
    .clk(clk), .reset(reset), .start(start), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .color(color), .src_done(src_done), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ack(fb_ack), .busy(busy),
    .frame_done(frame_done), .pix_count(pix_count), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  // Writes complete at the next rising edge when we && ack are seen here
  always @(negedge clk) begin
    if (reset === 1'b0 && fb_we === 1'b1 && fb_ack === 1'b1)
      obs_q.push_back({fb_addr, fb_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ack_rand) fb_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic model_accept(input int x, input int y, input logic [11:0] c);
    if (x >= 0 && x < H && y >= 0 && y < V) begin
      exp_q.push_back({15'(y * H + x), c});
      exp_kept++;
    end else begin
      exp_clip++;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_kept = 0;
    exp_clip = 0;
  endtask

  task automatic send_point(input int x, input int y, input logic [11:0] c, output int waited);
    bit acc = 1'b0;
    pt_valid = 1'b1;
    pt_x = 9'(x);
    pt_y = 8'(y);
    color = c;
    waited = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = pt_ready;
      if (!acc) waited++;
      tick();
    end
    pt_valid = 1'b0;
    if (acc) model_accept(x, y, c);
    else begin
      total_cnt++;
      $display("FAIL send_point timeout x=%0d y=%0d", x, y);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_x = '0; pt_y = '0; color = '0;
    src_done = 1'b0; fb_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (fb_we !== 1'b0) $display("FAIL reset_fb_we got=%b exp=0", fb_we); else pass_cnt++;
    total_cnt++; if (pt_ready !== 1'b0) $display("FAIL reset_pt_ready got=%b exp=0", pt_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'd0) $display("FAIL reset_pix got=%0d exp=0", pix_count); else pass_cnt++;
    total_cnt++; if (clip_count !== 16'd0) $display("FAIL reset_clip got=%0d exp=0", clip_count); else pass_cnt++;
    total_cnt++; if (fb_addr !== 15'd0) $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int w;
    logic [26:0] e, got;
    do_start();
    total_cnt++; if (busy !== 1'b1) $display("FAIL t1_busy got=%b exp=1", busy); else pass_cnt++;
    fb_ack = 1'b0;
    send_point(10, 20, 12'hF00, w);
    e = exp_q[0];
    total_cnt++; if (fb_we !== 1'b1) $display("FAIL t1_we_latency got=%b exp=1", fb_we); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      total_cnt++; if (fb_addr !== e[26:12]) $display("FAIL t1_addr_hold got=%0d exp=%0d", fb_addr, e[26:12]); else pass_cnt++;
      total_cnt++; if (fb_data !== e[11:0]) $display("FAIL t1_data_hold got=%h exp=%h", fb_data, e[11:0]); else pass_cnt++;
      tick();
    end
    fb_ack = 1'b1;
    tick();
    fb_ack = 1'b0;
    total_cnt++; if (fb_we !== 1'b0) $display("FAIL t1_we_after_ack got=%b exp=0", fb_we); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'(exp_kept)) $display("FAIL t1_pix got=%0d exp=%0d", pix_count, exp_kept); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL t1_write missing exp=%h", e);
      else begin
        got = obs_q.pop_front();
        if (got !== e) $display("FAIL t1_write got=%h exp=%h", got, e); else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL t1_extra_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_clip();
    int xs[4] = '{-1, 160, 5, 159};
    int ys[4] = '{5, 0, 120, 119};
    int w;
    logic [26:0] e, got;
    fb_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_point(xs[k], ys[k], 12'(12'h0A0 + k), w);
      total_cnt++; if (w != 0) $display("FAIL t2_ready_stall pt=%0d got=%0d exp=0", k, w); else pass_cnt++;
    end
    repeat (3) tick();
    fb_ack = 1'b0;
    total_cnt++; if (clip_count !== 16'(exp_clip)) $display("FAIL t2_clip got=%0d exp=%0d", clip_count, exp_clip); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'(exp_kept)) $display("FAIL t2_pix got=%0d exp=%0d", pix_count, exp_kept); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL t2_write missing exp=%h", e);
      else begin
        got = obs_q.pop_front();
        if (got !== e) $display("FAIL t2_write got=%h exp=%h", got, e); else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL t2_extra_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_full();
    int w;
    logic [26:0] e, got;
    fb_ack = 1'b0;
    for (int k = 0; k < 8; k++)
      send_point(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 12'($urandom), w);
    total_cnt++; if (pt_ready !== 1'b0) $display("FAIL t3_ready_full got=%b exp=0", pt_ready); else pass_cnt++;
    tick();
    total_cnt++; if (pt_ready !== 1'b0) $display("FAIL t3_ready_hold got=%b exp=0", pt_ready); else pass_cnt++;
    fb_ack = 1'b1;
    tick();
    fb_ack = 1'b0;
    total_cnt++; if (pt_ready !== 1'b1) $display("FAIL t3_ready_after_pop got=%b exp=1", pt_ready); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'(exp_kept - 7)) $display("FAIL t3_pix got=%0d exp=%0d", pix_count, exp_kept - 7); else pass_cnt++;
    fb_ack = 1'b1;
    for (int i = 0; i < 50 && fb_we; i++) tick();
    fb_ack = 1'b0;
    total_cnt++; if (fb_we !== 1'b0) $display("FAIL t3_drain_timeout got=%b exp=0", fb_we); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL t3_order missing exp=%h", e);
      else begin
        got = obs_q.pop_front();
        if (got !== e) $display("FAIL t3_order got=%h exp=%h", got, e); else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL t3_extra_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_done();
    int w;
    logic [26:0] e, got;
    fb_ack = 1'b0;
    for (int k = 0; k < 3; k++)
      send_point(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 12'($urandom), w);
    start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if (pix_count !== 16'(exp_kept - 3)) $display("FAIL t4_start_ignored got=%0d exp=%0d", pix_count, exp_kept - 3); else pass_cnt++;
    src_done = 1'b1;
    tick();
    total_cnt++; if (pt_ready !== 1'b0) $display("FAIL t4_drain_ready got=%b exp=0", pt_ready); else pass_cnt++;
    src_done = 1'b0;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL t4_drain_busy got=%b exp=1", busy); else pass_cnt++;
    total_cnt++; if (fb_we !== 1'b1) $display("FAIL t4_drain_we got=%b exp=1", fb_we); else pass_cnt++;
    fb_ack = 1'b1;
    for (int i = 0; i < 20 && fb_we; i++) tick();
    fb_ack = 1'b0;
    total_cnt++; if (fb_we !== 1'b0) $display("FAIL t4_ack_timeout got=%b exp=0", fb_we); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL t4_done_early got=%b exp=0", frame_done); else pass_cnt++;
    tick();
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL t4_done_pulse got=%b exp=1", frame_done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL t4_busy_fall got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'(exp_kept)) $display("FAIL t4_pix got=%0d exp=%0d", pix_count, exp_kept); else pass_cnt++;
    tick();
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL t4_done_single got=%b exp=0", frame_done); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL t4_write missing exp=%h", e);
      else begin
        got = obs_q.pop_front();
        if (got !== e) $display("FAIL t4_write got=%h exp=%h", got, e); else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL t4_extra_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w;
    logic [26:0] e, got;
    do_start();
    fb_ack = 1'b0;
    send_point(3, 4, 12'h123, w);
    send_point(200, 4, 12'h456, w);
    send_point(7, 8, 12'h789, w);
    src_done = 1'b1;
    tick();
    src_done = 1'b0;
    total_cnt++; if (fb_we !== 1'b1) $display("FAIL t5_pre_we got=%b exp=1", fb_we); else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if (fb_we !== 1'b0) $display("FAIL t5_async_we got=%b exp=0", fb_we); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL t5_async_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (clip_count !== 16'd0) $display("FAIL t5_async_clip got=%0d exp=0", clip_count); else pass_cnt++;
    exp_q.delete();
    obs_q.delete();
    exp_kept = 0;
    exp_clip = 0;
    tick();
    reset = 1'b0;
    tick();
    do_start();
    fb_ack = 1'b1;
    send_point(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 12'($urandom), w);
    send_point(-5, 10, 12'hABC, w);
    src_done = 1'b1;
    for (int i = 0; i < 50 && !frame_done; i++) tick();
    src_done = 1'b0;
    fb_ack = 1'b0;
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL t5_restart_done got=%b exp=1", frame_done); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'(exp_kept)) $display("FAIL t5_pix got=%0d exp=%0d", pix_count, exp_kept); else pass_cnt++;
    total_cnt++; if (clip_count !== 16'(exp_clip)) $display("FAIL t5_clip got=%0d exp=%0d", clip_count, exp_clip); else pass_cnt++;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL t5_write missing exp=%h", e);
      else begin
        got = obs_q.pop_front();
        if (got !== e) $display("FAIL t5_write got=%h exp=%h", got, e); else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL t5_extra_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_circle();
    int px[$];
    int py[$];
    int x, y, d, w, n;
    int cx = 80;
    int cy = 60;
    logic [26:0] e, got;
    x = 0; y = 8; d = 1 - 8;
    while (x <= y) begin
      px.push_back(cx + x); py.push_back(cy + y);
      px.push_back(cx - x); py.push_back(cy + y);
      px.push_back(cx + x); py.push_back(cy - y);
      px.push_back(cx - x); py.push_back(cy - y);
      px.push_back(cx + y); py.push_back(cy + x);
      px.push_back(cx - y); py.push_back(cy + x);
      px.push_back(cx + y); py.push_back(cy - x);
      px.push_back(cx - y); py.push_back(cy - x);
      if (d < 0) d = d + 2 * x + 3;
      else begin d = d + 2 * (x - y) + 5; y--; end
      x++;
    end
    n = px.size();
    do_start();
    fb_ack = 1'b1;
    for (int k = 0; k < n; k++) send_point(px[k], py[k], 12'hFFF, w);
    src_done = 1'b1;
    for (int i = 0; i < 100 && !frame_done; i++) tick();
    src_done = 1'b0;
    fb_ack = 1'b0;
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL t6_done got=%b exp=1", frame_done); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'(n)) $display("FAIL t6_pix got=%0d exp=%0d", pix_count, n); else pass_cnt++;
    total_cnt++; if (clip_count !== 16'd0) $display("FAIL t6_clip got=%0d exp=0", clip_count); else pass_cnt++;
    tick();
    foreach (obs_q[k]) begin
      total_cnt++;
      if (int'(obs_q[k][26:12]) < 52 * H + 72 || int'(obs_q[k][26:12]) > 68 * H + 88)
        $display("FAIL t6_range got=%0d exp=%0d..%0d", obs_q[k][26:12], 52 * H + 72, 68 * H + 88);
      else pass_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL t6_write missing exp=%h", e);
      else begin
        got = obs_q.pop_front();
        if (got !== e) $display("FAIL t6_write got=%h exp=%h", got, e); else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL t6_extra_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_random();
    int w;
    logic [26:0] e, got;
    do_start();
    ack_rand = 1'b1;
    for (int k = 0; k < 80; k++) begin
      send_point(int'($urandom_range(0, 200)) - 20, int'($urandom_range(0, 147)) - 20, 12'($urandom), w);
      if ($urandom_range(0, 3) == 0) tick();
    end
    src_done = 1'b1;
    for (int i = 0; i < 500 && !frame_done; i++) tick();
    src_done = 1'b0;
    ack_rand = 1'b0;
    fb_ack = 1'b0;
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL rnd_done got=%b exp=1", frame_done); else pass_cnt++;
    total_cnt++; if (pix_count !== 16'(exp_kept)) $display("FAIL rnd_pix got=%0d exp=%0d", pix_count, exp_kept); else pass_cnt++;
    total_cnt++; if (clip_count !== 16'(exp_clip)) $display("FAIL rnd_clip got=%0d exp=%0d", clip_count, exp_clip); else pass_cnt++;
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) $display("FAIL rnd_write missing exp=%h", e);
      else begin
        got = obs_q.pop_front();
        if (got !== e) $display("FAIL rnd_write got=%h exp=%h", got, e); else pass_cnt++;
      end
    end
    total_cnt++; if (obs_q.size() != 0) $display("FAIL rnd_extra_writes got=%0d exp=0", obs_q.size()); else pass_cnt++;
  endtask

  initial begin
    exp_kept = 0;
    exp_clip = 0;
    test_reset();
    test_single_write();
    test_clip();
    test_full();
    test_done();
    test_reset_mid();
    test_circle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
